// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   - muldiv_op_t    : funct3 encodings of the M-extension operations
//   - muldiv_state_t : control FSM states
//   - XLEN_DEFAULT, DIV_BY_ZERO_Q, INT_MIN
//   - small decode helpers on muldiv_op_t
// Related build option: MULDIV_FAST_MUL_EN (see muldiv_unit).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] DIV_BY_ZERO_Q = {XLEN_DEFAULT{1'b1}};
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN       = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    // Divide-class operations (DIV, DIVU, REM, REMU)
    function automatic logic op_is_div(input muldiv_op_t op);
        logic [2:0] f;
        f = op;
        return f[2];
    endfunction

    // Remainder-class operations
    function automatic logic op_is_rem(input muldiv_op_t op);
        logic rem;
        case (op)
            OP_REM, OP_REMU: rem = 1'b1;
            default:         rem = 1'b0;
        endcase
        return rem;
    endfunction

    // rs1 is interpreted as signed
    function automatic logic op_sign1(input muldiv_op_t op);
        logic s;
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is interpreted as signed
    function automatic logic op_sign2(input muldiv_op_t op);
        logic s;
        case (op)
            OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the execute stage and muldiv_unit.
//   start/flush/in1/in2/funct3 : request side (master drives)
//   busy/done/result/negative/zero : response side (slave drives)
// -----------------------------------------------------------------------------
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();
    logic            start;
    logic            flush;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [2:0]      funct3;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            negative;
    logic            zero;

    modport master (
        output start, flush, in1, in2, funct3,
        input  busy, done, result, negative, zero
    );

    modport slave (
        input  start, flush, in1, in2, funct3,
        output busy, done, result, negative, zero
    );
endinterface

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Combinational conditional two's-complement negate. Used as absolute value
// on operand entry (i_neg = operand sign) and as sign restore on exit.
//   i_val [W] : input value
//   i_neg     : 1 = negate
//   o_val [W] : i_neg ? -i_val : i_val
// -----------------------------------------------------------------------------
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit sitting next to the ALU.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.start  : one-cycle request, only sampled in IDLE
//   bus.flush  : abort, wins over every transition
//   bus.in1/in2/funct3 : operands and operation
//   bus.busy   : operation in flight (CALC/FIN)
//   bus.done   : one-cycle pulse, result valid
//   bus.result/negative/zero : registered result and ALU-style flags
// Build option: MULDIV_FAST_MUL_EN - multiplies use one combinational
// product and skip CALC; divides remain iterative.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    muldiv_state_t     r_state, w_next;
    muldiv_op_t        r_op, w_op_in;
    logic              r_busy, r_done, w_busy_nxt, w_done_nxt;
    logic              r_neg_q, r_neg_r;
    logic [XLEN-1:0]   r_opnd, r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_s1, w_s2, w_div_zero, w_div_ovf, w_special, w_fast_mul;
    logic [XLEN-1:0]   w_a_abs, w_b_abs, w_fin_val;
    logic [XLEN:0]     w_mul_add, w_div_diff;
    logic [2*XLEN-1:0] w_mul_step, w_div_step, w_fix_in, w_fixed;
    logic              w_fix_neg;

    assign w_op_in    = muldiv_op_t'(bus.funct3);
    assign w_s1       = op_sign1(w_op_in) & bus.in1[XLEN-1];
    assign w_s2       = op_sign2(w_op_in) & bus.in2[XLEN-1];
    assign w_div_zero = (bus.in2 == {XLEN{1'b0}});
    // Signed overflow: INT_MIN / -1
    assign w_div_ovf  = op_sign2(w_op_in) & (bus.in1 == INT_MIN) & (bus.in2 == DIV_BY_ZERO_Q);
    assign w_special  = op_is_div(w_op_in) & (w_div_zero | w_div_ovf);

    muldiv_signfix #(.W(XLEN)) u_abs1 (.i_val(bus.in1), .i_neg(w_s1), .o_val(w_a_abs));
    muldiv_signfix #(.W(XLEN)) u_abs2 (.i_val(bus.in2), .i_neg(w_s2), .o_val(w_b_abs));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_a_abs} * {{XLEN{1'b0}}, w_b_abs};
    assign w_fast_mul  = ~op_is_div(w_op_in);
`else
    assign w_fast_mul  = 1'b0;
`endif

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right
    assign w_mul_add  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_step = {w_mul_add, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; trial subtract on the shifted remainder
    assign w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    assign w_div_step = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Exit sign fix-up: remainder follows dividend sign, product/quotient follow sign1^sign2
    assign w_fix_in  = op_is_rem(r_op) ? {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]} :
                       op_is_div(r_op) ? {{XLEN{1'b0}}, r_acc[XLEN-1:0]} : r_acc;
    assign w_fix_neg = op_is_rem(r_op) ? r_neg_r : r_neg_q;

    muldiv_signfix #(.W(2*XLEN)) u_fix (.i_val(w_fix_in), .i_neg(w_fix_neg), .o_val(w_fixed));

    // Final word selection: high half only for MULH/MULHSU/MULHU
    always_comb begin
        w_fin_val = w_fixed[XLEN-1:0];
        case (r_op)
            OP_MULH, OP_MULHSU, OP_MULHU: w_fin_val = w_fixed[2*XLEN-1:XLEN];
            default:                      w_fin_val = w_fixed[XLEN-1:0];
        endcase
    end

    // State register plus registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.flush) begin
                    w_next = IDLE;
                end else if (bus.start) begin
                    if (w_special || w_fast_mul) begin
                        w_next = FIN;
                    end else begin
                        w_next = CALC;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    w_next = IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next = FIN;
                end else begin
                    w_next = CALC;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode for the registered busy/done
    always_comb begin
        w_busy_nxt = (w_next != IDLE);
        if ((r_state == FIN) && !bus.flush) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
    end

    // Datapath: operand capture, iteration, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_opnd   <= {XLEN{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_op  <= w_op_in;
                        r_cnt <= CNT_W'(XLEN-1);
                        if (w_special) begin
                            // Preload the final {remainder, quotient} with no sign fix-up
                            r_acc   <= w_div_zero ? {bus.in1, DIV_BY_ZERO_Q}
                                                  : {{XLEN{1'b0}}, INT_MIN};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (op_is_div(w_op_in)) begin
                            r_acc   <= {{XLEN{1'b0}}, w_a_abs};
                            r_opnd  <= w_b_abs;
                            r_neg_q <= w_s1 ^ w_s2;
                            r_neg_r <= w_s1;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            r_acc   <= w_fast_prod;
`else
                            r_acc   <= {{XLEN{1'b0}}, w_b_abs};
`endif
                            r_opnd  <= w_a_abs;
                            r_neg_q <= w_s1 ^ w_s2;
                            r_neg_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                        r_acc <= op_is_div(r_op) ? w_div_step : w_mul_step;
                    end
                end
                FIN: begin
                    if (!bus.flush) begin
                        r_result <= w_fin_val;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.negative = r_result[XLEN-1];
    assign bus.zero     = (r_result == {XLEN{1'b0}});

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Table-driven directed bench for muldiv_unit plus hand-written sequences for
// start-while-busy, flush, flush+start and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MK = 1;
`else
    localparam int MK = 33;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_k;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; k = edges after the accepting edge
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int k, output int bcnt, output bit ok);
        @(negedge clk);
        bus.funct3 = op;
        bus.in1    = a;
        bus.in2    = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bcnt = bus.busy ? 1 : 0;
        k  = 0;
        ok = 1'b0;
        while (k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, bcnt, seen;
        bit  ok;

        vecs[0]  = '{OP_MUL,    32'h0000000F, 32'h000000F0, 32'h00000E10, MK};
        vecs[1]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MK};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MK};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MK};
        vecs[4]  = '{OP_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, MK};
        vecs[5]  = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MK};
        vecs[6]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[7]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[8]  = '{OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 33};
        vecs[9]  = '{OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 33};
        vecs[10] = '{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[11] = '{OP_DIV,    32'h80000000, 32'h00000002, 32'hC0000000, 33};
        vecs[12] = '{OP_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
        vecs[13] = '{OP_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1};
        vecs[14] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[15] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.in1    = 32'h0;
        bus.in2    = 32'h0;
        bus.funct3 = 3'b000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_negative", bus.negative, 1'b0);
        chk("rst_zero", bus.zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, k, bcnt, ok);
            chk($sformatf("v%0d_done_seen", i), ok, 1'b1);
            chk($sformatf("v%0d_latency", i), k, vecs[i].exp_k);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_k);
            chk($sformatf("v%0d_result", i), bus.result, vecs[i].exp_res);
            chk($sformatf("v%0d_negative", i), bus.negative, vecs[i].exp_res[31]);
            chk($sformatf("v%0d_zero", i), bus.zero, (vecs[i].exp_res == 32'h0));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), bus.done, 1'b0);
            chk($sformatf("v%0d_hold", i), bus.result, vecs[i].exp_res);
        end

        // Start while busy is ignored: DIVU 100/7 runs, MUL 3x4 request dropped
        run_op(OP_DIVU, 32'd100, 32'd7, k, bcnt, ok);
        @(negedge clk);
        bus.funct3 = OP_DIVU;
        bus.in1    = 32'd100;
        bus.in2    = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.funct3 = OP_MUL;
        bus.in1    = 32'd3;
        bus.in2    = 32'd4;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (k < 100 && !bus.done) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy_start_done_seen", bus.done, 1'b1);
        chk("busy_start_result", bus.result, 32'd14);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("busy_start_no_queue", seen, 0);

        // Flush at iteration 10 of a DIV
        @(negedge clk);
        bus.funct3 = OP_DIV;
        bus.in1    = 32'd1000;
        bus.in2    = 32'd3;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_busy_before", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_done", bus.done, 1'b0);
        chk("flush_result", bus.result, 32'd14);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("flush_no_done", seen, 0);
        run_op(OP_MUL, 32'd3, 32'd4, k, bcnt, ok);
        chk("after_flush_latency", k, MK);
        chk("after_flush_result", bus.result, 32'd12);

        // Simultaneous flush and start in IDLE drops the start
        @(negedge clk);
        bus.funct3 = OP_DIVU;
        bus.in1    = 32'd100;
        bus.in2    = 32'd0;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_busy", bus.busy, 1'b0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("flush_start_no_done", seen, 0);
        chk("flush_start_result", bus.result, 32'd12);

        // Reset pulsed mid-CALC
        @(negedge clk);
        bus.funct3 = OP_DIV;
        bus.in1    = 32'd1000;
        bus.in2    = 32'd3;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_result", bus.result, 32'h0);
        chk("midrst_negative", bus.negative, 1'b0);
        chk("midrst_zero", bus.zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_DIVU, 32'd1000, 32'd3, k, bcnt, ok);
        chk("after_rst_latency", k, 33);
        chk("after_rst_result", bus.result, 32'd333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
